// File: rtl/ebus_diag_pkg.sv
// Shared types and ds field positions for the EBUS diagnostic responder.
// All EBUS words and ds fields use big-endian [0:N] bit numbering.
package ebus_diag_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAITLOW
  } tDiagState;

  localparam int DS_WRITE_BIT = 4;
  localparam int DS_IDX_MSB   = 5;
  localparam int DS_IDX_LSB   = 6;

  typedef bit [0:35] tEbusWord;

endpackage

// File: rtl/ebus_diag_responder.sv
// Target-side EBUS diagnostic responder: owns eight function codes starting at
// DS_BASE, writes four diagnostic registers and drives reads onto EBUS data.
module ebus_diag_responder
  import ebus_diag_pkg::*;
#(
  parameter logic [0:6] DS_BASE     = 7'o040,
  parameter int         HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [0:6] ds,
  input  logic       diagStrobe,
  input  tEbusWord   dataIn,
  output tEbusWord   dataOut,
  output logic       driving,
  output tEbusWord   diagReg0,
  output tEbusWord   diagReg1,
  output tEbusWord   diagReg2,
  output tEbusWord   diagReg3,
  output logic [0:3] wrPulse
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  tDiagState  state;
  logic       strobe_q;
  logic [3:0] hold_cnt;
  tEbusWord   diag_reg [4];

  logic       rise;
  logic       match;
  logic       is_read;
  logic [1:0] idx;

  // Only the upper four ds bits identify this board; the low three pick the function.
  always_comb begin
    rise    = diagStrobe & ~strobe_q;
    match   = (ds[0:3] == DS_BASE[0:3]);
    is_read = ds[DS_WRITE_BIT];
    idx     = ds[DS_IDX_MSB:DS_IDX_LSB];
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= IDLE;
      strobe_q <= 1'b0;
      hold_cnt <= '0;
      driving  <= 1'b0;
      dataOut  <= '0;
      wrPulse  <= '0;
      for (int i = 0; i < 4; i++) begin
        diag_reg[i] <= '0;
      end
    end else begin
      strobe_q <= diagStrobe;
      wrPulse  <= '0;
      case (state)
        IDLE: begin
          if (rise && match) begin
            if (is_read) begin
              dataOut  <= diag_reg[idx];
              driving  <= 1'b1;
              hold_cnt <= HOLD_LOAD;
              state    <= READ;
            end else begin
              diag_reg[idx] <= dataIn;
              wrPulse[idx]  <= 1'b1;
              state         <= WAITLOW;
            end
          end
        end
        // The window lasts until both the hold time has expired and the strobe is low.
        READ: begin
          if (hold_cnt != 4'd0) begin
            hold_cnt <= hold_cnt - 4'd1;
          end
          if (hold_cnt == 4'd0 && !diagStrobe) begin
            driving <= 1'b0;
            dataOut <= '0;
            state   <= IDLE;
          end
        end
        WAITLOW: begin
          if (!diagStrobe) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign diagReg0 = diag_reg[0];
  assign diagReg1 = diag_reg[1];
  assign diagReg2 = diag_reg[2];
  assign diagReg3 = diag_reg[3];

endmodule

// File: tb/tb_ebus_diag_responder.sv
// Directed, table-driven bench for ebus_diag_responder with DS_BASE=7'o040, HOLD_CYCLES=2.
module tb_ebus_diag_responder;
  import ebus_diag_pkg::*;

  logic       clk = 1'b0;
  logic       rstN;
  logic [0:6] ds;
  logic       diagStrobe;
  tEbusWord   dataIn;
  tEbusWord   dataOut;
  logic       driving;
  tEbusWord   diagReg0, diagReg1, diagReg2, diagReg3;
  logic [0:3] wrPulse;

  int checks = 0;
  int errors = 0;

  localparam tEbusWord W1 = 36'o123456701234;
  localparam tEbusWord W2 = 36'o765432107654;
  localparam tEbusWord W3 = 36'o111111111111;
  localparam tEbusWord W4 = 36'o400000000001;
  localparam tEbusWord WZ = 36'o0;

  ebus_diag_responder #(
    .DS_BASE(7'o040),
    .HOLD_CYCLES(2)
  ) dut (
    .clk(clk),
    .rstN(rstN),
    .ds(ds),
    .diagStrobe(diagStrobe),
    .dataIn(dataIn),
    .dataOut(dataOut),
    .driving(driving),
    .diagReg0(diagReg0),
    .diagReg1(diagReg1),
    .diagReg2(diagReg2),
    .diagReg3(diagReg3),
    .wrPulse(wrPulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       strobe;
    logic [0:6] ds;
    tEbusWord   din;
    logic       exp_drv;
    tEbusWord   exp_dout;
    logic [0:3] exp_wr;
    int         reg_idx;
    tEbusWord   exp_reg;
  } vec_t;

  vec_t vecs[$];

  function automatic tEbusWord regByIdx(input int idx);
    case (idx)
      0:       return diagReg0;
      1:       return diagReg1;
      2:       return diagReg2;
      default: return diagReg3;
    endcase
  endfunction

  // Drive inputs just after an edge, then sample 1 ns after the following edge.
  task automatic applyStimulus(input logic strobe, input logic [0:6] dsv, input tEbusWord din);
    diagStrobe = strobe;
    ds         = dsv;
    dataIn     = din;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic exp_drv, input tEbusWord exp_dout,
                             input logic [0:3] exp_wr);
    checks++;
    if (driving !== exp_drv) begin
      errors++;
      $display("[TB] FAIL %s driving: got %0b expected %0b", tag, driving, exp_drv);
    end
    checks++;
    if (dataOut !== exp_dout) begin
      errors++;
      $display("[TB] FAIL %s dataOut: got %o expected %o", tag, dataOut, exp_dout);
    end
    checks++;
    if (wrPulse !== exp_wr) begin
      errors++;
      $display("[TB] FAIL %s wrPulse: got %b expected %b", tag, wrPulse, exp_wr);
    end
  endtask

  task automatic checkReg(input string tag, input int idx, input tEbusWord exp);
    tEbusWord act;
    act = regByIdx(idx);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s diagReg%0d: got %o expected %o", tag, idx, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //              tag        stb   ds      din  drv  dout wr       idx reg
    vecs.push_back('{"wr1",     1'b1, 7'o041, W1, 1'b0, WZ, 4'b0100, 1, W1});
    vecs.push_back('{"wr1_end", 1'b0, 7'o041, WZ, 1'b0, WZ, 4'b0000, 1, W1});
    vecs.push_back('{"rd1_a",   1'b1, 7'o045, W2, 1'b1, W1, 4'b0000, 1, W1});
    vecs.push_back('{"rd1_b",   1'b0, 7'o045, WZ, 1'b1, W1, 4'b0000, 1, W1});
    vecs.push_back('{"rd1_rel", 1'b0, 7'o045, WZ, 1'b0, WZ, 4'b0000, 1, W1});
    vecs.push_back('{"ds000",   1'b1, 7'o000, W2, 1'b0, WZ, 4'b0000, 0, WZ});
    vecs.push_back('{"ds000_e", 1'b0, 7'o000, WZ, 1'b0, WZ, 4'b0000, 1, W1});
    vecs.push_back('{"ds051",   1'b1, 7'o051, W2, 1'b0, WZ, 4'b0000, 1, W1});
    vecs.push_back('{"ds051_e", 1'b0, 7'o051, WZ, 1'b0, WZ, 4'b0000, 1, W1});
    vecs.push_back('{"wr2",     1'b1, 7'o042, W2, 1'b0, WZ, 4'b0010, 2, W2});
    vecs.push_back('{"wr2_chg", 1'b1, 7'o043, W3, 1'b0, WZ, 4'b0000, 3, WZ});
    vecs.push_back('{"wr2_end", 1'b0, 7'o043, W3, 1'b0, WZ, 4'b0000, 2, W2});
    vecs.push_back('{"rd2_a",   1'b1, 7'o046, WZ, 1'b1, W2, 4'b0000, 2, W2});
    vecs.push_back('{"rd2_b",   1'b0, 7'o046, WZ, 1'b1, W2, 4'b0000, 2, W2});
    vecs.push_back('{"rd2_rel", 1'b0, 7'o046, WZ, 1'b0, WZ, 4'b0000, 2, W2});
    vecs.push_back('{"wr3",     1'b1, 7'o043, W3, 1'b0, WZ, 4'b0001, 3, W3});
    vecs.push_back('{"wr3_end", 1'b0, 7'o043, WZ, 1'b0, WZ, 4'b0000, 3, W3});
    vecs.push_back('{"rd3_a",   1'b1, 7'o047, WZ, 1'b1, W3, 4'b0000, 3, W3});
    vecs.push_back('{"rd3_b",   1'b0, 7'o047, WZ, 1'b1, W3, 4'b0000, 3, W3});
    vecs.push_back('{"rd3_rel", 1'b0, 7'o047, WZ, 1'b0, WZ, 4'b0000, 3, W3});
    vecs.push_back('{"wr0",     1'b1, 7'o040, W4, 1'b0, WZ, 4'b1000, 0, W4});
    vecs.push_back('{"wr0_end", 1'b0, 7'o040, WZ, 1'b0, WZ, 4'b0000, 0, W4});
    vecs.push_back('{"rd0_a",   1'b1, 7'o044, WZ, 1'b1, W4, 4'b0000, 0, W4});
    vecs.push_back('{"rd0_b",   1'b0, 7'o044, WZ, 1'b1, W4, 4'b0000, 0, W4});
    vecs.push_back('{"rd0_rel", 1'b0, 7'o044, WZ, 1'b0, WZ, 4'b0000, 0, W4});

    rstN       = 1'b0;
    ds         = 7'o000;
    diagStrobe = 1'b0;
    dataIn     = WZ;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", 1'b0, WZ, 4'b0000);
    for (int i = 0; i < 4; i++) checkReg("reset", i, WZ);
    rstN = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].strobe, vecs[i].ds, vecs[i].din);
      checkOutput(vecs[i].tag, vecs[i].exp_drv, vecs[i].exp_dout, vecs[i].exp_wr);
      checkReg(vecs[i].tag, vecs[i].reg_idx, vecs[i].exp_reg);
    end

    // Long strobe: window follows the strobe and releases the edge after it falls.
    applyStimulus(1'b1, 7'o045, WZ);
    checkOutput("long_0", 1'b1, W1, 4'b0000);
    for (int i = 1; i < 6; i++) begin
      applyStimulus(1'b1, 7'o045, WZ);
      checkOutput($sformatf("long_%0d", i), 1'b1, W1, 4'b0000);
    end
    applyStimulus(1'b0, 7'o045, WZ);
    checkOutput("long_rel", 1'b0, WZ, 4'b0000);

    // Second rise during READ, with a write code on ds, must not start anything.
    applyStimulus(1'b1, 7'o045, WZ);
    checkOutput("tog_a", 1'b1, W1, 4'b0000);
    applyStimulus(1'b0, 7'o045, WZ);
    checkOutput("tog_b", 1'b1, W1, 4'b0000);
    applyStimulus(1'b1, 7'o041, W2);
    checkOutput("tog_rise", 1'b1, W1, 4'b0000);
    applyStimulus(1'b1, 7'o041, W2);
    checkOutput("tog_hold", 1'b1, W1, 4'b0000);
    applyStimulus(1'b0, 7'o041, W2);
    checkOutput("tog_rel", 1'b0, WZ, 4'b0000);
    applyStimulus(1'b0, 7'o041, W2);
    checkOutput("tog_idle", 1'b0, WZ, 4'b0000);
    checkReg("tog_idle", 1, W1);

    // Asynchronous reset in the middle of a read window.
    applyStimulus(1'b1, 7'o045, WZ);
    checkOutput("rst_rd", 1'b1, W1, 4'b0000);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("rst_async", 1'b0, WZ, 4'b0000);
    for (int i = 0; i < 4; i++) checkReg("rst_async", i, WZ);
    diagStrobe = 1'b0;
    @(posedge clk);
    #2;
    rstN = 1'b1;
    applyStimulus(1'b0, 7'o045, WZ);
    checkOutput("post_rst_idle", 1'b0, WZ, 4'b0000);
    applyStimulus(1'b1, 7'o045, WZ);
    checkOutput("post_rst_rd", 1'b1, WZ, 4'b0000);
    applyStimulus(1'b0, 7'o045, WZ);
    checkOutput("post_rst_b", 1'b1, WZ, 4'b0000);
    applyStimulus(1'b0, 7'o045, WZ);
    checkOutput("post_rst_rel", 1'b0, WZ, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
